// File: rtl/stim_seq_pkg.sv
// Shared types and word-field helpers for the stimulus sequencer.
// A program word is laid out as {hold, obs, stim}, with stim in the low bits.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STIM_OFS    = 0;
  localparam int OBS_W       = 1;
  localparam int FIELD_MAX_W = 32;
  localparam int WORD_MAX_W  = 2 * FIELD_MAX_W + OBS_W;

  typedef struct packed {
    logic [FIELD_MAX_W-1:0] hold;
    logic                   obs;
    logic [FIELD_MAX_W-1:0] stim;
  } word_fields_t;

  function automatic int obs_ofs(input int in_w);
    return STIM_OFS + in_w;
  endfunction

  function automatic int hold_ofs(input int in_w);
    return STIM_OFS + in_w + OBS_W;
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] field_mask(input int w);
    logic [FIELD_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < FIELD_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Fields come back zero-extended to FIELD_MAX_W; callers slice to their widths.
  function automatic word_fields_t unpack_word(input logic [WORD_MAX_W-1:0] word,
                                               input int in_w, input int hold_w);
    word_fields_t f;
    f.stim = FIELD_MAX_W'(word >> STIM_OFS) & field_mask(in_w);
    f.obs  = 1'(word >> obs_ofs(in_w));
    f.hold = FIELD_MAX_W'(word >> hold_ofs(in_w)) & field_mask(hold_w);
    return f;
  endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// Loader/control and DUT-drive bundle of the stimulus sequencer.
// master = bench/loader side, slave = sequencer.
interface stim_sequencer_if #(
  parameter int IN_W   = 5,
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 64,
  parameter int LOOP_W = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WORD_W = HOLD_W + 1 + IN_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_drop;
  logic [ADDR_W:0]   len;
  logic              run;
  logic              loop_en;
  logic              pause;
  logic              abort;
  logic [IN_W-1:0]   stim;
  logic              obs;
  logic              valid;
  logic              step;
  logic [ADDR_W-1:0] pc;
  logic [LOOP_W-1:0] loop_cnt;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, len, run, loop_en, pause, abort,
    input  wr_drop, stim, obs, valid, step, pc, loop_cnt, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, run, loop_en, pause, abort,
    output wr_drop, stim, obs, valid, step, pc, loop_cnt, busy, done
  );
endinterface

// File: rtl/stim_prog_mem.sv
// Program store: register array, synchronous write, asynchronous read.
module stim_prog_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WORD_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Replays a loaded program of {hold, obs, stim} words onto a DUT, one word per
// step, with per-word hold, looping, pause and abort.
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int IN_W   = 5,
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 64,
  parameter int LOOP_W = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WORD_W = HOLD_W + 1 + IN_W
) (
  input logic             clock,
  input logic             reset,
  stim_sequencer_if.slave bus
);

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_r, pc_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [ADDR_W:0]   len_r, len_n;
  logic [LOOP_W-1:0] loop_r, loop_n;
  logic [IN_W-1:0]   stim_r, stim_n;
  logic              obs_r, obs_n;
  logic              valid_r, valid_n;
  logic              step_r, step_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic              drop_r, drop_n;

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_word;
  word_fields_t      word_f;
  logic [IN_W-1:0]   word_stim;
  logic              word_obs;
  logic [HOLD_W-1:0] word_hold;
  logic              unused_fields;
  logic              at_last;
  logic [ADDR_W:0]   len_clamped;

  assign mem_we = bus.wr_en && (state != PLAY);

  stim_prog_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_mem (
    .clock  (clock),
    .we     (mem_we),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_word)
  );

  assign at_last = ({1'b0, pc_r} == (len_r - (ADDR_W+1)'(1)));

  // The single read port serves both "start at word 0" and "advance to pc+1".
  assign rd_addr = (state == PLAY && !at_last) ? (pc_r + ADDR_W'(1)) : '0;

  assign word_f        = unpack_word(WORD_MAX_W'(rd_word), IN_W, HOLD_W);
  assign word_stim     = word_f.stim[IN_W-1:0];
  assign word_obs      = word_f.obs;
  assign word_hold     = word_f.hold[HOLD_W-1:0];
  assign unused_fields = ^word_f;

  assign len_clamped = (bus.len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.len;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_r;
    hold_n  = hold_cnt;
    len_n   = len_r;
    loop_n  = loop_r;
    stim_n  = stim_r;
    obs_n   = obs_r;
    valid_n = valid_r;
    step_n  = 1'b0;
    busy_n  = busy_r;
    done_n  = done_r;
    drop_n  = bus.wr_en && (state == PLAY);

    if (bus.abort) begin
      state_n = IDLE;
      stim_n  = '0;
      obs_n   = 1'b0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.run && (bus.len != '0)) begin
            state_n = PLAY;
            len_n   = len_clamped;
            pc_n    = '0;
            loop_n  = '0;
            stim_n  = word_stim;
            obs_n   = word_obs;
            hold_n  = word_hold;
            valid_n = 1'b1;
            step_n  = 1'b1;
            busy_n  = 1'b1;
            done_n  = 1'b0;
          end
        end
        PLAY: begin
          if (!bus.pause) begin
            if (hold_cnt != '0) begin
              hold_n = hold_cnt - HOLD_W'(1);
            end else if (!at_last) begin
              pc_n   = pc_r + ADDR_W'(1);
              stim_n = word_stim;
              obs_n  = word_obs;
              hold_n = word_hold;
              step_n = 1'b1;
            end else if (bus.loop_en) begin
              pc_n   = '0;
              stim_n = word_stim;
              obs_n  = word_obs;
              hold_n = word_hold;
              loop_n = loop_r + LOOP_W'(1);
              step_n = 1'b1;
            end else begin
              // Finishing the last word counts as a completed pass too.
              state_n = DONE;
              stim_n  = '0;
              obs_n   = 1'b0;
              valid_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              loop_n  = loop_r + LOOP_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r    <= '0;
      loop_r  <= '0;
      stim_r  <= '0;
      obs_r   <= 1'b0;
      valid_r <= 1'b0;
      step_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      pc_r    <= pc_n;
      loop_r  <= loop_n;
      stim_r  <= stim_n;
      obs_r   <= obs_n;
      valid_r <= valid_n;
      step_r  <= step_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      drop_r  <= drop_n;
    end
    hold_cnt <= hold_n;
    len_r    <= len_n;
  end

  assign bus.stim     = stim_r;
  assign bus.obs      = obs_r;
  assign bus.valid    = valid_r;
  assign bus.step     = step_r;
  assign bus.pc       = pc_r;
  assign bus.loop_cnt = loop_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.wr_drop  = drop_r;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: the expected trace comes from expanding the
// program into a per-cycle timeline and walking it, skipping paused cycles.
module tb_stim_sequencer;
  localparam int IN_W   = 5;
  localparam int HOLD_W = 4;
  localparam int DEPTH  = 64;
  localparam int LOOP_W = 8;
  localparam int ADDR_W = 6;
  localparam int WORD_W = HOLD_W + 1 + IN_W;
  localparam int VEC_W  = 5 + IN_W + ADDR_W + LOOP_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stim_sequencer_if #(.IN_W(IN_W), .HOLD_W(HOLD_W), .DEPTH(DEPTH), .LOOP_W(LOOP_W)) bus ();

  stim_sequencer #(.IN_W(IN_W), .HOLD_W(HOLD_W), .DEPTH(DEPTH), .LOOP_W(LOOP_W)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [WORD_W-1:0] prog [DEPTH];
  int tl_idx[$];
  bit tl_first[$];

  function automatic logic [VEC_W-1:0] observed();
    return {bus.valid, bus.step, bus.busy, bus.done, bus.obs, bus.stim, bus.pc, bus.loop_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [WORD_W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    prog[a] = d;
  endtask

  task automatic load_basic();
    write_word(0, {4'd0, 1'b0, 5'h01});
    write_word(1, {4'd2, 1'b1, 5'h1F});
    write_word(2, {4'd0, 1'b0, 5'h0A});
  endtask

  task automatic stop_play();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  // Start a run and compare every cycle against the walked timeline.
  task automatic run_check(input string name, input int len, input bit loop, input int ncycles,
                           input int pstart, input int plen, input bit prand);
    int eff, total, pos, idx;
    bit adv, fin, p;
    logic [LOOP_W-1:0] passes;
    logic [VEC_W-1:0] expv, got;
    logic [WORD_W-1:0] w;
    eff = (len > DEPTH) ? DEPTH : len;
    tl_idx.delete();
    tl_first.delete();
    for (int i = 0; i < eff; i++) begin
      for (int h = 0; h <= int'(prog[i][WORD_W-1:IN_W+1]); h++) begin
        tl_idx.push_back(i);
        tl_first.push_back(h == 0);
      end
    end
    total = (ncycles > 0) ? ncycles : tl_idx.size() + 3;
    bus.len     = (ADDR_W+1)'(len);
    bus.loop_en = loop;
    bus.run     = 1'b1;
    tick();
    bus.run = 1'b0;
    pos = 0; adv = 1'b1; fin = 1'b0; passes = '0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (fin) begin
        expv = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, IN_W'(0), ADDR_W'(eff - 1), passes};
      end else begin
        idx  = tl_idx[pos];
        w    = prog[idx];
        expv = {1'b1, adv && tl_first[pos], 1'b1, 1'b0, w[IN_W], w[IN_W-1:0], ADDR_W'(idx), passes};
      end
      got = observed();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: {valid,step,busy,done,obs,stim,pc,loop} got %h expected %h",
                 name, c, got, expv);
      end
      p = (c >= pstart && c < pstart + plen) || (prand && $urandom_range(0, 3) == 0);
      bus.pause = p;
      tick();
      if (!fin) begin
        if (p) begin
          adv = 1'b0;
        end else begin
          pos++;
          adv = 1'b1;
          if (pos == tl_idx.size()) begin
            passes++;
            if (loop) pos = 0;
            else fin = 1'b1;
          end
        end
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_drop: got %b expected 0", bus.wr_drop);
    end
    tick();
  endtask

  task automatic test_basic();
    load_basic();
    run_check("basic", 3, 1'b0, 8, 0, 0, 1'b0);
  endtask

  task automatic test_loop();
    run_check("loop", 3, 1'b1, 12, 0, 0, 1'b0);
    stop_play();
  endtask

  task automatic test_pause();
    run_check("pause", 3, 1'b0, 12, 2, 4, 1'b0);
  endtask

  task automatic test_abort();
    logic [VEC_W-1:0] expv;
    bus.len = 7'd3; bus.loop_en = 1'b0; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    bus.abort = 1'b1; bus.run = 1'b1;
    tick();
    bus.abort = 1'b0; bus.run = 1'b0;
    expv = {5'b0, IN_W'(0), ADDR_W'(1), LOOP_W'(0)};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expv) begin
        errors++;
        $display("FAIL abort_idle_%0d: got %h expected %h", k, observed(), expv);
      end
      tick();
    end
    bus.abort = 1'b1; bus.run = 1'b1;
    tick();
    bus.abort = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== expv) begin
      errors++;
      $display("FAIL abort_over_run_idle: got %h expected %h", observed(), expv);
    end
    tick();
  endtask

  task automatic test_wr_drop();
    bit seen;
    write_word(3, 10'($urandom));
    @(negedge clk);
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wr_accept_no_drop: got %b expected 0", bus.wr_drop);
    end
    bus.len = 7'd3; bus.loop_en = 1'b0; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 10'h3FF;
    tick();
    bus.wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL wr_drop_pulse: got %b expected 1", bus.wr_drop);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop_single: got %b expected 0", bus.wr_drop);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = bus.done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wr_drop_done_timeout: done got 0 expected 1");
    end
    run_check("replay_after_drop", 3, 1'b0, 8, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.len = 7'd3; bus.loop_en = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({observed(), bus.wr_drop} !== '0) begin
      errors++;
      $display("FAIL reset_mid_play: got %h expected 0", {observed(), bus.wr_drop});
    end
    bus.len = '0; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (observed() !== '0) begin
        errors++;
        $display("FAIL run_len0_%0d: got %h expected 0", k, observed());
      end
      tick();
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < DEPTH; i++)
      write_word(i, {HOLD_W'($urandom_range(0, 1)), 1'($urandom), IN_W'($urandom)});
    run_check("clamp70", 70, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    bit lp;
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 12);
      lp  = 1'($urandom);
      run_check($sformatf("random%0d", it), len, lp, 40, 0, 0, 1'b1);
      stop_play();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.run = 1'b0; bus.loop_en = 1'b0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_abort();
    test_wr_drop();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Synthesizable, parametrised successor to the concolic bench opcode player. Holds a loadable program of stimulus words and replays them onto a DUT's primary inputs plus an observation strobe, one word per step. Adds per-word hold counts, looping, pause/abort and a load port in place of file preloading. Sits between bench/loader logic and the design under test.

Parameters:
IN_W, 5, width of the stimulus vector driven to the DUT.
HOLD_W, 4, width of the per-word hold field; a word is applied for hold+1 cycles.
DEPTH, 64, number of program words.
ADDR_W, $clog2(DEPTH), derived address width; not overridden.
LOOP_W, 8, width of the completed-loop counter.
WORD_W, HOLD_W+1+IN_W, derived; word layout is {hold, obs, stim}.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  program write strobe
wr_addr  in  ADDR_W  program write address
wr_data  in  WORD_W  program word {hold, obs, stim}
wr_drop  out  1  one-cycle pulse: write refused because busy
len  in  ADDR_W+1  program length in words, sampled on accepted run
run  in  1  start playback
loop_en  in  1  live: wrap to word 0 after last word
pause  in  1  live: freeze playback
abort  in  1  stop playback, return to IDLE
stim  out  IN_W  stimulus to DUT
obs  out  1  observation strobe to DUT
valid  out  1  stim/obs currently carry a program word
step  out  1  one-cycle pulse on the first cycle of each applied word
pc  out  ADDR_W  index of the word currently applied
loop_cnt  out  LOOP_W  completed passes since run
busy  out  1  state is PLAY
done  out  1  level: program finished, until next run or reset

Behaviour:
- All outputs registered. Reset (any state, including mid-playback) gives: state IDLE; stim=0, obs=0, valid=0, step=0, pc=0, loop_cnt=0, busy=0, done=0, wr_drop=0. Program memory is not cleared.
- Memory: DEPTH x WORD_W register array; synchronous write, asynchronous read.
- Writes accepted in IDLE or DONE. wr_en while busy: no write; wr_drop=1 next cycle.
- States: IDLE, PLAY, DONE.
- IDLE/DONE: on run=1, abort=0, len!=0: latch min(len, DEPTH); next cycle PLAY with word 0 applied (latency 1), pc=0, step=1, valid=1, busy=1, done=0, loop_cnt=0, hold counter = word0.hold. run with len==0: ignored.
- PLAY, not paused: if hold counter != 0, decrement it; outputs unchanged; step=0. If 0 and pc != len-1, apply word pc+1 next cycle, step=1. If 0 and pc == len-1: when loop_en=1, apply word 0, loop_cnt+1 (wraps modulo 2^LOOP_W), step=1; otherwise DONE next cycle: stim=0, obs=0, valid=0, busy=0, done=1, pc holds last index, and loop_cnt increments by 1.
- pause=1 in PLAY: hold counter, pc and outputs frozen; step=0; valid stays 1.
- abort=1 in any state: IDLE next cycle; stim/obs/valid/step/busy/done = 0; pc and loop_cnt retained. abort has priority over run and pause. run while PLAY: ignored.
- len > DEPTH: clamped to DEPTH.

Decomposition:
- Shared package stim_seq_pkg: state enum (IDLE, PLAY, DONE), word field offset/width localparams, and a function that unpacks a word into hold/obs/stim.
- One natural sub-module: stim_prog_mem (register-array program store with write port and async read port). The FSM, counters and output registers stay in the top.

Test Plan:
- Load 3 words {0,0,5'h01},{2,1,5'h1F},{0,0,5'h0A}; len=3, run -> stim 01 (1 cycle), 1F with obs=1 (3 cycles), 0A (1 cycle); step pulses at cycles 1, 2, 5; done=1 at cycle 6, valid=0, loop_cnt=1.
- Same program with loop_en=1 for 12 cycles -> sequence repeats with period 5; loop_cnt increments at each wrap to pc=0.
- pause held 4 cycles during word 1 -> word 1 is applied for 7 cycles total, with no extra step pulse.
- abort during word 1, run asserted in the same cycle -> next cycle IDLE, valid=0, busy=0, done=0.
- wr_en during PLAY to addr 0 -> wr_drop pulse; a replay after done still shows the original word 0.
- reset mid-PLAY, then run with len=0 -> all outputs 0 and the block stays IDLE; then len=70 with DEPTH=64 -> plays exactly 64 words.
